// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states, error codes and
// frame field sizes.
package program_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_HDR_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   // States in which a frame is being received and bytes are accepted.
   function automatic logic is_active(input state_e s);
      return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects four accepted bytes into a little-endian 32-bit word and flags
// the cycle in which the fourth byte arrives.
module loader_word_assembler (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic        o_word_done,
   output logic [31:0] o_word
);

   logic [1:0]  r_idx;
   logic [23:0] r_buf;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx <= 2'd0;
         r_buf <= 24'd0;
      end else if (i_clear) begin
         r_idx <= 2'd0;
      end else if (i_accept) begin
         r_idx <= r_idx + 2'd1;
         case (r_idx)
            2'd0:    r_buf[7:0]   <= i_byte;
            2'd1:    r_buf[15:8]  <= i_byte;
            2'd2:    r_buf[23:16] <= i_byte;
            default: r_buf        <= r_buf;
         endcase
      end
   end

   // The top byte is taken straight from the bus so the word is ready in the accept cycle.
   assign o_word_done = i_accept && (r_idx == 2'd3);
   assign o_word      = {i_byte, r_buf};

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction memory writer: receives a framed byte stream, writes
// words from address 0, checks the checksum and holds the core until loaded.
//
// Handshake: a byte transfers on a rising edge where i_rx_valid and o_rx_ready
// are both high; i_rx_data is ignored in every other cycle.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 0,
   parameter bit BOOT_HOLD      = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic                  i_rx_valid,
   input  logic [7:0]            i_rx_data,
   output logic                  o_rx_ready,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   output logic                  o_cpu_hold,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [1:0]            o_err_code,
   output logic [ADDR_WIDTH:0]   o_word_count,
   output state_e                o_dbg_state
);

   localparam int MAX_WORDS = 1 << ADDR_WIDTH;

   state_e                r_state, w_next;
   logic                  r_rx_ready, r_busy, r_done, r_error, r_cpu_hold, r_mem_we;
   logic [1:0]            r_err_code, w_err_set;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic [ADDR_WIDTH:0]   r_word_count, r_n;
   logic [7:0]            r_n_lo, r_csum;
   logic [31:0]           r_to_cnt;

   logic                  w_accept, w_start_ok, w_len_ok, w_last_word, w_csum_ok, w_timeout;
   logic                  w_word_done;
   logic [31:0]           w_word;
   logic [15:0]           w_n;
   logic [7:0]            w_csum_sum;
   logic                  w_rx_ready_n, w_busy_n, w_done_n, w_error_n, w_hold_n;

   assign w_accept    = i_rx_valid && r_rx_ready;
   assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                    (r_state == ST_ERROR));
   assign w_n         = {i_rx_data, r_n_lo};
   assign w_len_ok    = (w_n != 16'd0) && ({16'd0, w_n} <= 32'(MAX_WORDS));
   assign w_last_word = w_word_done && ((r_word_count + 1'b1) == r_n);
   assign w_csum_sum  = r_csum + i_rx_data;
   assign w_csum_ok   = (w_csum_sum == 8'h00);
   assign w_timeout   = (TIMEOUT_CYCLES > 0) && is_active(r_state) && !w_accept &&
                        (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

   loader_word_assembler u_asm (
      .i_clk       (i_clk),
      .i_rst_n     (i_reset_n),
      .i_clear     (w_start_ok),
      .i_accept    (w_accept && (r_state == ST_DATA)),
      .i_byte      (i_rx_data),
      .o_word_done (w_word_done),
      .o_word      (w_word)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_err_set = ERR_NONE;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: if (i_start) w_next = ST_HDR_LO;
         ST_HDR_LO: if (w_accept) w_next = ST_HDR_HI;
         ST_HDR_HI: begin
            if (w_accept) begin
               if (w_len_ok) begin
                  w_next = ST_DATA;
               end else begin
                  w_next    = ST_ERROR;
                  w_err_set = ERR_LEN;
               end
            end
         end
         ST_DATA: if (w_last_word) w_next = ST_CSUM;
         ST_CSUM: begin
            if (w_accept) begin
               if (w_csum_ok) begin
                  w_next = ST_DONE;
               end else begin
                  w_next    = ST_ERROR;
                  w_err_set = ERR_CSUM;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_timeout) begin
         w_next    = ST_ERROR;
         w_err_set = ERR_TIMEOUT;
      end
   end

   // Status flags are derived from the upcoming state so they register alongside it.
   always_comb begin
      w_rx_ready_n = is_active(w_next);
      w_busy_n     = is_active(w_next);
      w_done_n     = (w_next == ST_DONE);
      w_error_n    = (w_next == ST_ERROR);
      w_hold_n     = (w_next == ST_IDLE) ? r_cpu_hold : (w_next != ST_DONE);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rx_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_cpu_hold <= BOOT_HOLD;
         r_err_code <= ERR_NONE;
      end else begin
         r_rx_ready <= w_rx_ready_n;
         r_busy     <= w_busy_n;
         r_done     <= w_done_n;
         r_error    <= w_error_n;
         r_cpu_hold <= w_hold_n;
         if (w_start_ok)                r_err_code <= ERR_NONE;
         else if (w_err_set != ERR_NONE) r_err_code <= w_err_set;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= 32'd0;
         r_word_count <= '0;
         r_n          <= '0;
         r_n_lo       <= 8'd0;
         r_csum       <= 8'd0;
         r_to_cnt     <= 32'd0;
      end else begin
         r_mem_we <= w_word_done;
         if (w_word_done) begin
            r_mem_addr  <= r_word_count[ADDR_WIDTH-1:0];
            r_mem_wdata <= w_word;
         end
         if (w_start_ok)       r_word_count <= '0;
         else if (w_word_done) r_word_count <= r_word_count + 1'b1;
         if (w_accept && (r_state == ST_HDR_LO)) r_n_lo <= i_rx_data;
         if (w_accept && (r_state == ST_HDR_HI) && w_len_ok) r_n <= w_n[ADDR_WIDTH:0];
         if (w_start_ok)                               r_csum <= 8'd0;
         else if (w_accept && (r_state == ST_DATA))    r_csum <= w_csum_sum;
         if (w_start_ok || w_accept || !is_active(r_state)) r_to_cnt <= 32'd0;
         else                                               r_to_cnt <= r_to_cnt + 32'd1;
      end
   end

   assign o_rx_ready   = r_rx_ready;
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_cpu_hold   = r_cpu_hold;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;
   assign o_err_code   = r_err_code;
   assign o_word_count = r_word_count;
   assign o_dbg_state  = r_state;

endmodule
